// File: rtl/fm25l16_spi_engine_if.sv
// Command handshake between the spi_mem arbiter and the FM25L16 SPI engine.
// The arbiter drives the master modport; the engine implements the slave modport.
interface fm25l16_spi_engine_if;
  logic        start;
  logic        ready;
  logic [1:0]  op;
  logic [10:0] addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        done;

  modport master (
    output start, op, addr, wr_data,
    input  ready, rd_data, done
  );

  modport slave (
    input  start, op, addr, wr_data,
    output ready, rd_data, done
  );
endinterface

// File: rtl/fm25l16_spi_engine.sv
// FM25L16 FRAM SPI mode-0 transaction engine.
// Takes one command per accepted start, shifts opcode/address/data MSB-first,
// captures the READ data byte and pulses done once the chip-select gap has elapsed.
// Build option FM25_AUTO_WREN_EN: a WRITE is automatically preceded by its own
// WREN frame and a chip-select gap, with a single done at the very end.
module fm25l16_spi_engine #(
  parameter int CLK_DIV     = 2,
  parameter int CS_HIGH_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fm25l16_spi_engine_if.slave  cmd,
  output logic                 spi_clk,
  output logic                 spi_cs,
  output logic                 spi_so,
  input  logic                 spi_si
);

`ifdef FM25_AUTO_WREN_EN
  localparam bit AUTO_WREN = 1'b1;
`else
  localparam bit AUTO_WREN = 1'b0;
`endif

  localparam logic [1:0]  OP_READ  = 2'b00;
  localparam logic [1:0]  OP_WRITE = 2'b01;
  localparam logic [1:0]  OP_WREN  = 2'b10;
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_HIGH_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, PRE_WREN, GAP, SHIFT, CS_TAIL, GAP_END, DONE
  } state_t;

  state_t      state, state_next;
  logic [1:0]  cmd_op;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [15:0] div_cnt;
  logic [15:0] gap_cnt;
  logic [5:0]  bit_cnt;
  logic [5:0]  frame_len;
  logic [31:0] shift_out;
  logic [7:0]  shift_in;
  logic [7:0]  rd_data_q;
  logic        accept;
  logic        tick;
  logic        prefix_now;
  logic        frame_load;
  logic [31:0] load_word;
  logic [5:0]  load_bits;

  // Complete frame contents, opcode always left-aligned in the top byte
  function automatic logic [31:0] frame_word(input logic [1:0] o, input logic [10:0] a,
                                             input logic [7:0] d);
    case (o)
      OP_READ:  frame_word = {8'h03, 5'b0, a, 8'h00};
      OP_WRITE: frame_word = {8'h02, 5'b0, a, d};
      OP_WREN:  frame_word = {8'h06, 24'h0};
      default:  frame_word = {8'h04, 24'h0};
    endcase
  endfunction

  function automatic logic [5:0] frame_bits(input logic [1:0] o);
    frame_bits = (o == OP_READ || o == OP_WRITE) ? 6'd32 : 6'd8;
  endfunction

  assign accept     = cmd.start && (state == IDLE || state == DONE);
  assign tick       = (div_cnt == DIV_LAST);
  assign prefix_now = AUTO_WREN && (cmd.op == OP_WRITE);
  assign frame_load = accept || (state == GAP && state_next == SHIFT);

  // Choose the next frame: fresh command at accept, latched command after the WREN gap
  always_comb begin
    load_word = frame_word(cmd_op, cmd_addr, cmd_data);
    load_bits = frame_bits(cmd_op);
    if (state == IDLE || state == DONE) begin
      if (prefix_now) begin
        load_word = {8'h06, 24'h0};
        load_bits = 6'd8;
      end else begin
        load_word = frame_word(cmd.op, cmd.addr, cmd.wr_data);
        load_bits = frame_bits(cmd.op);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state sequencing through frame, tail and chip-select gap
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = prefix_now ? PRE_WREN : SHIFT;
        else        state_next = IDLE;
      end
      PRE_WREN: if (tick && !spi_clk && bit_cnt == frame_len) state_next = GAP;
      GAP:      if (gap_cnt == GAP_LAST) state_next = SHIFT;
      SHIFT:    if (tick && spi_clk && bit_cnt == frame_len - 6'd1) state_next = CS_TAIL;
      CS_TAIL:  if (tick) state_next = GAP_END;
      GAP_END:  if (gap_cnt == GAP_LAST) state_next = DONE;
      default:  state_next = IDLE;
    endcase
  end

  // Handshake outputs follow the state directly
  always_comb begin
    cmd.ready   = (state == IDLE) || (state == DONE);
    cmd.done    = (state == DONE);
    cmd.rd_data = rd_data_q;
  end

  // SPI pin timing, shift registers and command latch
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_op    <= 2'b00;
      cmd_addr  <= 11'h000;
      cmd_data  <= 8'h00;
      div_cnt   <= 16'h0;
      gap_cnt   <= 16'h0;
      bit_cnt   <= 6'd0;
      frame_len <= 6'd0;
      shift_out <= 32'h0;
      shift_in  <= 8'h00;
      rd_data_q <= 8'h00;
      spi_clk   <= 1'b0;
      spi_cs    <= 1'b1;
      spi_so    <= 1'b0;
    end else begin
      if ((state == PRE_WREN || state == SHIFT || state == CS_TAIL) && !tick)
        div_cnt <= div_cnt + 16'd1;
      else
        div_cnt <= 16'h0;

      if ((state == GAP || state == GAP_END) && state_next == state)
        gap_cnt <= gap_cnt + 16'd1;
      else
        gap_cnt <= 16'h0;

      if (accept) begin
        cmd_op   <= cmd.op;
        cmd_addr <= cmd.addr;
        cmd_data <= cmd.wr_data;
      end

      if (frame_load) begin
        shift_out <= load_word;
        frame_len <= load_bits;
        bit_cnt   <= 6'd0;
        spi_clk   <= 1'b0;
        spi_cs    <= 1'b0;
        spi_so    <= load_word[31];
      end else if ((state == PRE_WREN || state == SHIFT) && tick) begin
        if (spi_clk) begin
          spi_clk   <= 1'b0;
          bit_cnt   <= bit_cnt + 6'd1;
          shift_out <= {shift_out[30:0], 1'b0};
          spi_so    <= shift_out[30];
        end else if (bit_cnt != frame_len) begin
          spi_clk <= 1'b1;
          if (state == SHIFT && cmd_op == OP_READ && bit_cnt >= 6'd24)
            shift_in <= {shift_in[6:0], spi_si};
        end else begin
          spi_cs <= 1'b1;
          spi_so <= 1'b0;
        end
      end else if (state == CS_TAIL && tick) begin
        spi_cs <= 1'b1;
        spi_so <= 1'b0;
      end

      if (state == GAP_END && state_next == DONE && cmd_op == OP_READ)
        rd_data_q <= shift_in;
    end
  end

endmodule
